// File: rtl/counterup16_seq_ctrl.sv
// Sequencing controller for the 16-bit up-counter: arm, count 0..term, signal completion.
// Optional `COUNTER_SEQ_PAUSE_EN adds a pause input that stalls counting in RUN.
module counterup16_seq_ctrl #(
    parameter int WIDTH      = 16,
    parameter int PCNT_WIDTH = 8
) (
    input  logic                  clock0,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    input  logic [WIDTH-1:0]      term,
    input  logic                  ack,
`ifdef COUNTER_SEQ_PAUSE_EN
    input  logic                  pause,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic [PCNT_WIDTH-1:0] period_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [PCNT_WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0]      term_q, term_d;
    logic                  mode_q, mode_d;
    logic                  run_stall;

`ifdef COUNTER_SEQ_PAUSE_EN
    assign run_stall = pause;
`else
    assign run_stall = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = done_q;
        period_d = period_q;
        term_d   = term_q;
        mode_d   = mode_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    term_d  = term;
                    mode_d  = auto_reload;
                    count_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // done is a single-cycle pulse here; only a terminal hit re-asserts it
                done_d = 1'b0;
                if (stop) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (!run_stall) begin
                    if (count_q == term_q) begin
                        period_d = period_q + PCNT_WIDTH'(1);
                        done_d   = 1'b1;
                        if (mode_q) begin
                            count_d = '0;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
            end
            DONE: begin
                if (ack) begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock0) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            period_q <= '0;
            term_q   <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            period_q <= period_d;
            term_q   <= term_d;
            mode_q   <= mode_d;
        end
    end

    assign count      = count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign period_cnt = period_q;

endmodule

// File: tb/tb_counterup16_seq_ctrl.sv
// Self-checking bench for counterup16_seq_ctrl; expectations come from closed-form arithmetic on k,
// the number of effective counting edges since the start edge. Honours `COUNTER_SEQ_PAUSE_EN.
module tb_counterup16_seq_ctrl;

    localparam int W = 16;
    localparam int P = 8;

    logic         clock0 = 1'b0;
    logic         reset, start, stop, auto_reload, ack, pause;
    logic [W-1:0] term;
    logic [W-1:0] count;
    logic         busy, done;
    logic [P-1:0] period_cnt;
    logic [25:0]  obs;

    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;
    int unsigned  m_term   = 0;
    bit           m_mode   = 1'b0;
    logic [7:0]   m_pbase  = '0;

    counterup16_seq_ctrl #(.WIDTH(W), .PCNT_WIDTH(P)) dut (
        .clock0      (clock0),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .term        (term),
        .ack         (ack),
`ifdef COUNTER_SEQ_PAUSE_EN
        .pause       (pause),
`endif
        .count       (count),
        .busy        (busy),
        .done        (done),
        .period_cnt  (period_cnt)
    );

    always #5 clock0 = ~clock0;

    assign obs = {count, busy, done, period_cnt};

    // Expected {count, busy, done, period_cnt} after k effective edges of a run started with m_term/m_mode.
    function automatic logic [25:0] model_run(int unsigned k);
        logic [31:0] cnt, per;
        logic        dn;
        if (m_mode) begin
            cnt = k % (m_term + 1);
            dn  = (k > 0) && (cnt == 0);
            per = m_pbase + k / (m_term + 1);
        end else begin
            cnt = (k < m_term) ? k : m_term;
            dn  = (k > m_term);
            per = m_pbase + ((k > m_term) ? 1 : 0);
        end
        return {cnt[15:0], 1'b1, dn, per[7:0]};
    endfunction

    // Expected outputs once the run is left (stop or ack): count/period frozen, busy and done low.
    function automatic logic [25:0] idle_exp(int unsigned k);
        logic [25:0] e;
        e = model_run(k);
        return {e[25:10], 2'b00, e[7:0]};
    endfunction

    task automatic step();
        @(posedge clock0);
        #1;
    endtask

    task automatic arm(int unsigned t, bit mode);
        term        = W'(t);
        auto_reload = mode;
        start       = 1'b1;
        m_term      = t;
        m_mode      = mode;
        step();
        start       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; stop = 1'b0; ack = 1'b0; pause = 1'b0;
        term = 16'd5; auto_reload = 1'b1;
        step(); step();
        n_checks++;
        if (obs !== 26'd0) begin n_fail++; $display("FAIL reset_held: got %h expected %h", obs, 26'd0); end
        reset = 1'b0; start = 1'b0;
        step();
        n_checks++;
        if (obs !== 26'd0) begin n_fail++; $display("FAIL reset_release: got %h expected %h", obs, 26'd0); end
        m_pbase = '0;
    endtask

    task automatic test_one_shot();
        logic [25:0] e;
        arm(3, 1'b0);
        for (int unsigned k = 0; k <= 6; k++) begin
            if (k > 0) step();
            e = model_run(k);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL one_shot k=%0d: got %h expected %h", k, obs, e); end
        end
        ack = 1'b1; step(); ack = 1'b0;
        e = idle_exp(6);
        m_pbase = e[7:0];
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL one_shot_ack: got %h expected %h", obs, e); end
    endtask

    task automatic test_auto_reload();
        logic [25:0] e;
        arm(2, 1'b1);
        for (int unsigned k = 0; k <= 12; k++) begin
            if (k > 0) step();
            e = model_run(k);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL auto_t2 k=%0d: got %h expected %h", k, obs, e); end
        end
        stop = 1'b1; step(); stop = 1'b0;
        e = idle_exp(12);
        m_pbase = e[7:0];
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL auto_t2_stop: got %h expected %h", obs, e); end
        arm(0, 1'b1);
        for (int unsigned k = 0; k <= 5; k++) begin
            if (k > 0) step();
            e = model_run(k);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL auto_t0 k=%0d: got %h expected %h", k, obs, e); end
        end
        stop = 1'b1; step(); stop = 1'b0;
        e = idle_exp(5);
        m_pbase = e[7:0];
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL auto_t0_stop: got %h expected %h", obs, e); end
    endtask

    task automatic test_stop_conflict();
        logic [25:0] e;
        arm(10, 1'b0);
        for (int unsigned k = 1; k <= 5; k++) step();
        stop = 1'b1; step(); stop = 1'b0;
        e = idle_exp(5);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL stop_run: got %h expected %h", obs, e); end
        start = 1'b1; stop = 1'b1; term = 16'd3; step(); start = 1'b0; stop = 1'b0;
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL start_stop_idle: got %h expected %h", obs, e); end
        ack = 1'b1; step(); ack = 1'b0;
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL ack_idle: got %h expected %h", obs, e); end
        arm(1, 1'b0);
        for (int unsigned k = 1; k <= 4; k++) step();
        stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
        e = model_run(5);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL done_ignores_stop: got %h expected %h", obs, e); end
        ack = 1'b1; step(); ack = 1'b0;
        e = idle_exp(5);
        m_pbase = e[7:0];
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL done_ack: got %h expected %h", obs, e); end
    endtask

    task automatic test_boundary();
        logic [25:0] e;
        arm(65535, 1'b0);
        for (int unsigned k = 1; k <= 65536; k++) begin
            step();
            if (k == 65535 || k == 65536 || k % 16384 == 0) begin
                e = model_run(k);
                n_checks++;
                if (obs !== e) begin n_fail++; $display("FAIL term_max k=%0d: got %h expected %h", k, obs, e); end
            end
        end
        ack = 1'b1; step(); ack = 1'b0;
        e = idle_exp(65536);
        m_pbase = e[7:0];
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL term_max_ack: got %h expected %h", obs, e); end
        arm(0, 1'b1);
        for (int unsigned k = 1; k <= 256; k++) step();
        e = model_run(256);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL period_wrap: got %h expected %h", obs, e); end
        stop = 1'b1; step(); stop = 1'b0;
        e = idle_exp(256);
        m_pbase = e[7:0];
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL period_wrap_stop: got %h expected %h", obs, e); end
    endtask

    task automatic test_reset_mid_run();
        logic [25:0] e;
        arm(20, 1'b1);
        for (int unsigned k = 1; k <= 7; k++) step();
        e = model_run(7);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL pre_reset k=7: got %h expected %h", obs, e); end
        reset = 1'b1; step(); reset = 1'b0;
        m_pbase = '0;
        n_checks++;
        if (obs !== 26'd0) begin n_fail++; $display("FAIL reset_mid_run: got %h expected %h", obs, 26'd0); end
        step();
        n_checks++;
        if (obs !== 26'd0) begin n_fail++; $display("FAIL reset_stays_idle: got %h expected %h", obs, 26'd0); end
    endtask

`ifdef COUNTER_SEQ_PAUSE_EN
    task automatic test_pause();
        logic [25:0] e;
        arm(3, 1'b0);
        step(); step();
        pause = 1'b1;
        for (int unsigned p = 0; p < 4; p++) begin
            step();
            e = model_run(2);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL pause_hold p=%0d: got %h expected %h", p, obs, e); end
        end
        pause = 1'b0;
        for (int unsigned k = 3; k <= 5; k++) begin
            step();
            e = model_run(k);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL pause_resume k=%0d: got %h expected %h", k, obs, e); end
        end
        ack = 1'b1; step(); ack = 1'b0;
        e = idle_exp(5);
        m_pbase = e[7:0];
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL pause_ack: got %h expected %h", obs, e); end
    endtask
`endif

    task automatic test_random();
        logic [25:0] e;
        int unsigned k, cycles;
        bit          in_done, paused_run;
        for (int unsigned it = 0; it < 30; it++) begin
            arm($urandom_range(0, 12), 1'($urandom_range(0, 1)));
            e = model_run(0);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL rand_start it=%0d: got %h expected %h", it, obs, e); end
            k = 0;
            cycles = $urandom_range(1, 40);
            for (int unsigned c = 0; c < cycles; c++) begin
                in_done     = !m_mode && (k > m_term);
                term        = W'($urandom);
                auto_reload = 1'($urandom);
                start       = 1'($urandom);
                ack         = in_done ? 1'b0 : 1'($urandom);
                stop        = in_done ? 1'($urandom) : 1'b0;
`ifdef COUNTER_SEQ_PAUSE_EN
                pause       = ($urandom_range(0, 3) == 0);
`endif
                paused_run  = pause && !in_done;
                step();
                if (!paused_run) k++;
                e = model_run(k);
                if (paused_run) e[8] = 1'b0;
                n_checks++;
                if (obs !== e) begin n_fail++; $display("FAIL rand_run it=%0d k=%0d: got %h expected %h", it, k, obs, e); end
            end
            start = 1'b0; pause = 1'b0; ack = 1'b0; stop = 1'b0;
            if (!m_mode && (k > m_term)) begin
                ack = 1'b1; step(); ack = 1'b0;
            end else begin
                stop = 1'b1; step(); stop = 1'b0;
            end
            e = idle_exp(k);
            m_pbase = e[7:0];
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL rand_end it=%0d: got %h expected %h", it, obs, e); end
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_stop_conflict();
`ifdef COUNTER_SEQ_PAUSE_EN
        test_pause();
`endif
        test_random();
        test_boundary();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
